aes_in_packer: RTL and testbench
================================

# aes_in_packer

Upstream input stage for the AES `cipher` core. It accepts plaintext as a stream of `DATA_W`-bit words over a valid/ready handshake and assembles each group of words into one 128-bit block. It double-buffers blocks, so the next block can be filled while the cipher works on the current one. For each block it issues a one-cycle start to the cipher's `ready_i`, holds `plain_text_i` stable, and releases the buffer on the cipher's `done_o`.

## Interface
- `DATA_W`, default 32: input word width; legal values 8, 16, 32, 64, 128; `N = 128/DATA_W` words per block.
- `CNT_W`, default 16: width of the completed-block counter.

- `clk_i  in  1`: clock, rising edge.
- `rst_ni  in  1`: reset, asynchronous, active-low.
- `s_valid_i  in  1`: input word valid.
- `s_data_i  in  DATA_W`: input word.
- `s_last_i  in  1`: final word of the message; used only when padding is compiled in.
- `s_ready_o  out  1`: the block can accept a word this cycle.
- `aes_start_o  out  1`: one-cycle start pulse; drives the cipher's `ready_i`.
- `plain_text_o  out  128`: block handed to the cipher; drives `plain_text_i`.
- `aes_done_i  in  1`: cipher `done_o`; one-cycle completion pulse.
- `busy_o  out  1`: a block is loaded or in flight.
- `pad_o  out  1`: the block in flight was zero-padded.
- `blk_cnt_o  out  CNT_W`: number of completed blocks; wraps.

## Operation
- **Word ordering:** the first word of a block goes in the MSBs. Word `i` occupies bits `[127-i*DATA_W -: DATA_W]`, which is FIPS-197 byte order.
- **Fill buffer:** `fill_reg` (128 bits), word counter `cnt` (0..N-1), flag `fill_full`.
  - `s_ready_o = !fill_full`.
  - A word is accepted on any edge where `s_valid_i && s_ready_o`.
  - An accepted word is written at position `cnt`, and `cnt` increments.
  - Accepting word N-1 sets `fill_full` and resets `cnt` to 0.
- **Hold buffer state machine**, states `H_EMPTY`, `H_LOAD`, `H_BUSY`:
  - `H_EMPTY`: if `fill_full`, then `hold_reg <= fill_reg`, `fill_full <= 0`, and the machine moves to `H_LOAD`.
  - `H_LOAD`: `aes_start_o = 1` (Moore output, exactly one cycle). The machine always moves to `H_BUSY`. `aes_done_i` is ignored in this state.
  - `H_BUSY`: on `aes_done_i`, `blk_cnt_o` increments. If `fill_full` at the same edge, the fill buffer transfers into hold and the machine goes directly to `H_LOAD`. Otherwise it goes to `H_EMPTY`.
- **Outputs from the hold buffer:**
  - `plain_text_o = hold_reg`, stable from `H_LOAD` through the edge that samples `aes_done_i`.
  - `busy_o = (state != H_EMPTY)`.
- **Simultaneous events:**
  - A word accept and a fill-to-hold transfer on the same edge cannot both occur: acceptance requires `!fill_full`, and the transfer requires `fill_full`.
  - `aes_done_i` arriving in `H_EMPTY` is ignored.
- **Back-pressure:** with both buffers occupied, `s_ready_o = 0` until a transfer frees the fill buffer.
- **Reset mid-operation:** all buffers, counters and state clear asynchronously. Any partial or in-flight block is discarded. The cipher is reset by the same `rst_ni`.

## Timing
- **Reset values:**
  - `s_ready_o = 1`
  - `aes_start_o = 0`, `busy_o = 0`, `pad_o = 0`
  - `plain_text_o = 0`, `blk_cnt_o = 0`
  - state `H_EMPTY`, `cnt = 0`
- **Latency:** if the last word is accepted at edge E0 and hold is empty, the transfer occurs at E1 and `aes_start_o` is high in the cycle following E1.
- **Back-to-back blocks:** if `aes_done_i` is sampled at edge Ed with fill full, the next start pulse is in the cycle following Ed.
- **Throughput:** one word per cycle while the fill buffer is not full.
- **Counter wrap:** `blk_cnt_o` wraps from `2^CNT_W-1` to 0.
- **`DATA_W = 128`:** N = 1, `cnt` is a single constant-0 bit, and every accepted word fills a block.

## Configuration
- Macro: `AES_PACK_ZERO_PAD_EN`.
- **Defined:**
  - `s_last_i` accepted at `cnt < N-1` zero-fills the remaining words of `fill_reg`, sets `fill_full`, and marks the block padded.
  - `pad_o` follows the block into hold and is valid while `busy_o`.
  - `s_last_i` at `cnt == N-1` behaves as a normal block with no pad flag.
- **Undefined:**
  - `s_last_i` is ignored and `pad_o` is tied to 0.
  - A partial block waits for more words indefinitely.

## Test plan
- **Single block:** with `DATA_W = 32`, send words `0x00112233`, `0x44556677`, `0x8899aabb`, `0xccddeeff` on consecutive cycles.
  - `plain_text_o = 128'h00112233445566778899aabbccddeeff`.
  - `aes_start_o` is high for exactly one cycle, two edges after the last word.
  - After `aes_done_i`, `blk_cnt_o = 1` and `busy_o = 0`.
- **Double buffering:** stream 12 words continuously while the cipher holds `aes_done_i` low for 20 cycles.
  - `s_ready_o` drops after word 8 and `plain_text_o` is unchanged.
  - At the `aes_done_i` edge, block 2 loads and the next start pulse follows the next cycle.
  - `s_ready_o` returns high in the cycle after that edge; words 9-12 are then accepted.
- **Reset mid-block:** drop `rst_ni` after 2 of 4 words with a block in `H_BUSY`.
  - All outputs return to reset values immediately.
  - The next 4 words form a clean block; the 2 discarded words do not appear.
- **Spurious done:** pulse `aes_done_i` in `H_EMPTY` and in `H_LOAD` → no state change and `blk_cnt_o` unchanged.
- **Padding, `AES_PACK_ZERO_PAD_EN` defined:** send `0xdeadbeef` with `s_last_i = 1` → `plain_text_o = 128'hdeadbeef000...0` and `pad_o = 1`. Without the macro, the same stimulus produces no start pulse.
- **Counter wrap:** with `CNT_W = 2`, complete 5 blocks → `blk_cnt_o` sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/aes_in_packer_if.sv
// Plaintext word stream into aes_in_packer: valid/ready handshake with last-word marker.
interface aes_in_packer_if #(
  parameter int DATA_W = 32
) ();
  logic              s_valid_i;
  logic [DATA_W-1:0] s_data_i;
  logic              s_last_i;
  logic              s_ready_o;

  modport master (output s_valid_i, output s_data_i, output s_last_i, input s_ready_o);
  modport slave  (input s_valid_i, input s_data_i, input s_last_i, output s_ready_o);
endinterface

// File: rtl/aes_in_packer.sv
// Packs DATA_W-bit plaintext words into 128-bit blocks, double-buffered, feeding the AES cipher.
// Optional zero padding of a short final block: define AES_PACK_ZERO_PAD_EN.
module aes_in_packer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  aes_in_packer_if.slave   s,
  output logic             aes_start_o,
  output logic [127:0]     plain_text_o,
  input  logic             aes_done_i,
  output logic             busy_o,
  output logic             pad_o,
  output logic [CNT_W-1:0] blk_cnt_o
);

  localparam int N  = 128 / DATA_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {H_EMPTY, H_LOAD, H_BUSY} state_t;

  state_t        state, state_nxt;
  logic [127:0]  fill_reg, fill_nxt, hold_reg;
  logic [CW-1:0] cnt;
  logic          fill_full;
  logic          accept, blk_done, xfer, last_word, pad_now;

  assign accept     = s.s_valid_i && !fill_full;
  assign s.s_ready_o = !fill_full;
  assign blk_done   = (state == H_BUSY) && aes_done_i;
  // Fill-to-hold transfer only ever happens with a full fill buffer, so it never collides with an accept.
  assign xfer       = fill_full && ((state == H_EMPTY) || blk_done);

`ifdef AES_PACK_ZERO_PAD_EN
  logic fill_pad, hold_pad;
  assign pad_now = s.s_last_i && (int'(cnt) < N - 1);
  assign pad_o   = busy_o && hold_pad;
`else
  logic unused_last;
  assign unused_last = s.s_last_i;
  assign pad_now     = 1'b0;
  assign pad_o       = 1'b0;
`endif

  assign last_word = (int'(cnt) == N - 1) || pad_now;

  // Word i lands in bits [127-i*DATA_W -: DATA_W]; a padded last word zeroes everything after it.
  always_comb begin
    fill_nxt = fill_reg;
    for (int i = 0; i < N; i++) begin
      if (i == int'(cnt))
        fill_nxt[127-i*DATA_W -: DATA_W] = s.s_data_i;
      else if (pad_now && (i > int'(cnt)))
        fill_nxt[127-i*DATA_W -: DATA_W] = '0;
    end
  end

  // Fill buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_reg  <= '0;
      cnt       <= '0;
      fill_full <= 1'b0;
    end else if (accept) begin
      fill_reg <= fill_nxt;
      if (last_word) begin
        fill_full <= 1'b1;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else if (xfer) begin
      fill_full <= 1'b0;
    end
  end

  // Hold buffer and completed-block counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_reg  <= '0;
      blk_cnt_o <= '0;
    end else begin
      if (xfer)
        hold_reg <= fill_reg;
      if (blk_done)
        blk_cnt_o <= blk_cnt_o + CNT_W'(1);
    end
  end

`ifdef AES_PACK_ZERO_PAD_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_pad <= 1'b0;
      hold_pad <= 1'b0;
    end else begin
      if (accept && last_word)
        fill_pad <= pad_now;
      if (xfer)
        hold_pad <= fill_pad;
    end
  end
`endif

  // Hold state machine: register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= H_EMPTY;
    else         state <= state_nxt;
  end

  // Hold state machine: next state (done is ignored outside H_BUSY)
  always_comb begin
    state_nxt = state;
    case (state)
      H_EMPTY: if (fill_full) state_nxt = H_LOAD;
      H_LOAD:  state_nxt = H_BUSY;
      H_BUSY:  if (aes_done_i) state_nxt = fill_full ? H_LOAD : H_EMPTY;
      default: state_nxt = H_EMPTY;
    endcase
  end

  // Hold state machine: Moore outputs
  always_comb begin
    aes_start_o = (state == H_LOAD);
    busy_o      = (state != H_EMPTY);
  end

  assign plain_text_o = hold_reg;

endmodule

// File: tb/tb_aes_in_packer.sv
// Bench for aes_in_packer: event-level reference model checked every cycle plus directed literal checks.
module tb_aes_in_packer;
  localparam int DW = 32;
  localparam int N  = 128 / DW;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_in_packer_if #(.DATA_W(DW)) s_if ();
  logic          aes_start, aes_done, busy, pad;
  logic [127:0]  pt;
  logic [CW-1:0] blk;

  aes_in_packer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .s(s_if),
    .aes_start_o(aes_start), .plain_text_o(pt), .aes_done_i(aes_done),
    .busy_o(busy), .pad_o(pad), .blk_cnt_o(blk)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // ---------------- reference model (block-level view) ----------------
  bit             m_fill_full = 0;
  logic [DW-1:0]  m_words[$];
  logic [127:0]   m_fill_blk = '0;
  logic [127:0]   m_hold = '0;
  bit             m_fill_pad = 0;
  bit             m_hold_pad = 0;
  int             m_phase = 0;     // 0 no block, 1 start cycle, 2 awaiting done
  int             m_blk = 0;

  function automatic logic [127:0] pack(input logic [DW-1:0] w[$]);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < w.size(); i++)
      b = b | (128'(w[i]) << (128 - DW * (i + 1)));
    return b;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_fill_full = 0; m_words.delete(); m_fill_blk = '0; m_hold = '0;
      m_fill_pad = 0; m_hold_pad = 0; m_phase = 0; m_blk = 0;
    end else begin
      bit acc, done_b, xf, padded;
      acc    = s_if.s_valid_i && !m_fill_full;
      done_b = (m_phase == 2) && aes_done;
      xf     = m_fill_full && (m_phase == 0 || done_b);
      if (done_b) m_blk = (m_blk + 1) % (1 << CW);
      if (xf) begin
        m_hold = m_fill_blk; m_hold_pad = m_fill_pad; m_fill_full = 0; m_phase = 1;
      end else if (m_phase == 1) m_phase = 2;
      else if (done_b) m_phase = 0;
      if (acc) begin
        m_words.push_back(s_if.s_data_i);
`ifdef AES_PACK_ZERO_PAD_EN
        padded = s_if.s_last_i && (m_words.size() < N);
`else
        padded = 0;
`endif
        if (m_words.size() == N || padded) begin
          m_fill_blk = pack(m_words); m_fill_pad = padded; m_fill_full = 1;
          m_words.delete();
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model
  initial forever begin
    @(negedge clk);
    check("m_ready", s_if.s_ready_o, !m_fill_full);
    check("m_start", aes_start, m_phase == 1);
    check("m_busy",  busy, m_phase != 0);
    check("m_plain", pt, m_hold);
    check("m_blkcnt", blk, m_blk[CW-1:0]);
    check("m_pad",   pad, m_hold_pad && (m_phase != 0));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w, input logic last);
    bit ok, r;
    s_if.s_valid_i = 1'b1;
    s_if.s_data_i  = w;
    s_if.s_last_i  = last;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      r = s_if.s_ready_o;
      step();
      if (r) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("push");
  endtask

  task automatic drop();
    s_if.s_valid_i = 1'b0;
    s_if.s_last_i  = 1'b0;
  endtask

  task automatic pulse_done();
    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
  endtask

  task automatic wait_start();
    bit seen;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (aes_start) begin seen = 1; break; end
      step();
    end
    if (!seen) timeout_fail("wait_start");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [CW-1:0] wrap_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    #500000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    s_if.s_valid_i = 1'b0; s_if.s_data_i = '0; s_if.s_last_i = 1'b0; aes_done = 1'b0;
    repeat (3) step();
    check("rst_ready", s_if.s_ready_o, 1);
    check("rst_start", aes_start, 0);
    check("rst_busy", busy, 0);
    check("rst_pad", pad, 0);
    check("rst_plain", pt, 0);
    check("rst_blkcnt", blk, 0);
    rst_n = 1'b1;
    step();

    // Single block
    push(32'h00112233, 0); push(32'h44556677, 0); push(32'h8899aabb, 0); push(32'hccddeeff, 0);
    drop();
    check("sb_full_ready", s_if.s_ready_o, 0);
    check("sb_nostart", aes_start, 0);
    step();
    check("sb_start", aes_start, 1);
    check("sb_plain", pt, 128'h00112233445566778899aabbccddeeff);
    aes_done = 1'b1;                 // spurious done while in the start cycle
    step();
    aes_done = 1'b0;
    check("sb_start_one", aes_start, 0);
    check("sb_busy_ld", busy, 1);
    check("sp_load_cnt", blk, 0);
    pulse_done();
    check("sb_blkcnt", blk, 1);
    check("sb_idle", busy, 0);
    pulse_done();                    // spurious done with nothing loaded
    check("sp_empty_cnt", blk, 1);
    check("sp_empty_busy", busy, 0);

    // Double buffering
    for (int i = 1; i <= 8; i++) push(32'h10000000 + i, 0);
    check("db_ready_low", s_if.s_ready_o, 0);
    check("db_plain1", pt, 128'h10000001_10000002_10000003_10000004);
    s_if.s_data_i = 32'h10000009;
    repeat (12) step();
    check("db_still_low", s_if.s_ready_o, 0);
    check("db_plain1_hold", pt, 128'h10000001_10000002_10000003_10000004);
    pulse_done();
    check("db_start2", aes_start, 1);
    check("db_plain2", pt, 128'h10000005_10000006_10000007_10000008);
    check("db_ready_back", s_if.s_ready_o, 1);
    check("db_blkcnt", blk, 2);
    for (int i = 9; i <= 12; i++) push(32'h10000000 + i, 0);
    drop();
    pulse_done();
    check("db_start3", aes_start, 1);
    check("db_plain3", pt, 128'h10000009_1000000a_1000000b_1000000c);
    step();

    // Reset with a block in flight and a partial block filling
    push(32'haaaa0001, 0); push(32'haaaa0002, 0);
    drop();
    #2 rst_n = 1'b0;
    #1;
    check("mr_ready", s_if.s_ready_o, 1);
    check("mr_start", aes_start, 0);
    check("mr_busy", busy, 0);
    check("mr_plain", pt, 0);
    check("mr_blkcnt", blk, 0);
    step();
    rst_n = 1'b1;
    step();

    // Counter wrap; the first block also shows the discarded words are gone
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < N; i++) push(32'hc0000000 + 16 * b + i, 0);
      drop();
      wait_start();
      if (b == 0) check("mr_clean", pt, 128'hc0000000_c0000001_c0000002_c0000003);
      step();
      pulse_done();
      check("wrap_cnt", blk, wrap_seq[b]);
    end

    // Short block with last marker
    push(32'hdeadbeef, 1);
    drop();
`ifdef AES_PACK_ZERO_PAD_EN
    step();
    check("pad_start", aes_start, 1);
    check("pad_plain", pt, 128'hdeadbeef_00000000_00000000_00000000);
    check("pad_flag", pad, 1);
    step();
    pulse_done();
    check("pad_clear", pad, 0);
`else
    repeat (4) step();
    check("nopad_busy", busy, 0);
    check("nopad_start", aes_start, 0);
    check("nopad_ready", s_if.s_ready_o, 1);
`endif
    do_reset();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      s_if.s_valid_i = ($urandom % 4) != 0;
      s_if.s_data_i  = $urandom;
      s_if.s_last_i  = ($urandom % 6) == 0;
      aes_done       = ($urandom % 3) == 0;
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end
    drop();
    aes_done = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
